// File: rtl/rv_fetch_mt.sv
// rtl/rv_fetch_mt.sv - multithreaded round-robin instruction fetch unit
// One PC/busy/epoch per thread; responses return in order and are matched via a tag FIFO.
module rv_fetch_mt #(
    parameter int          NTHREADS = 4,
    parameter int          TID_W    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NTHREADS-1:0] thread_en,
    input  logic                redirect_valid,
    input  logic [TID_W-1:0]    redirect_tid,
    input  logic [31:0]         redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [31:0]         imem_req_addr,
    input  logic                imem_rsp_valid,
    output logic                imem_rsp_ready,
    input  logic [31:0]         imem_rsp_data,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [TID_W-1:0]    if_tid,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_instr
);

    logic [31:0]         r_pc     [NTHREADS];
    logic [NTHREADS-1:0] r_busy;
    logic [NTHREADS-1:0] r_epoch;
    logic [TID_W-1:0]    r_rr;

    logic [TID_W-1:0]    r_tag_tid [NTHREADS];
    logic                r_tag_ep  [NTHREADS];
    logic [31:0]         r_tag_pc  [NTHREADS];
    logic [TID_W-1:0]    r_wr;
    logic [TID_W-1:0]    r_rd;
    logic [TID_W:0]      r_count;

    logic                r_if_valid;
    logic [TID_W-1:0]    r_if_tid;
    logic [31:0]         r_if_pc;
    logic [31:0]         r_if_instr;

    logic [NTHREADS-1:0] w_redir_mask;
    logic [NTHREADS-1:0] w_elig;
    logic                w_any;
    logic [TID_W-1:0]    w_sel;
    logic                w_req_fire;
    logic [31:0]         w_redir_target;
    logic [TID_W-1:0]    w_head_tid;
    logic                w_head_stale;
    logic                w_rsp_fire;
    logic                w_load;
    logic                w_kill;
    logic [NTHREADS-1:0] w_set_mask;
    logic [NTHREADS-1:0] w_clr_mask;

    assign w_redir_mask   = {{(NTHREADS-1){1'b0}}, redirect_valid} << redirect_tid;
    assign w_elig         = thread_en & ~r_busy & ~w_redir_mask;
    assign w_redir_target = redirect_pc & 32'hFFFF_FFFC;

    // First eligible thread at or after the round-robin pointer, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = 0; i < NTHREADS; i++) begin
            if (!w_any && w_elig[r_rr + TID_W'(i)]) begin
                w_any = 1'b1;
                w_sel = r_rr + TID_W'(i);
            end
        end
    end

    assign imem_req_valid = w_any && !rst;
    assign imem_req_addr  = r_pc[w_sel];
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A stale head tag never blocks: it is drained even while decode is stalled.
    assign w_head_tid     = r_tag_tid[r_rd];
    assign w_head_stale   = (r_count != '0) &&
                            ((r_tag_ep[r_rd] != r_epoch[w_head_tid]) || w_redir_mask[w_head_tid]);
    assign imem_rsp_ready = !r_if_valid || if_ready || w_head_stale;
    assign w_rsp_fire     = imem_rsp_valid && imem_rsp_ready && (r_count != '0);
    assign w_load         = w_rsp_fire && !w_head_stale;
    assign w_kill         = r_if_valid && !if_ready && redirect_valid && (redirect_tid == r_if_tid);

    assign w_set_mask = {{(NTHREADS-1){1'b0}}, w_req_fire} << w_sel;
    assign w_clr_mask = {{(NTHREADS-1){1'b0}}, w_rsp_fire} << w_head_tid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTHREADS; i++) begin
                r_pc[i]      <= RESET_PC;
                r_tag_tid[i] <= '0;
                r_tag_ep[i]  <= 1'b0;
                r_tag_pc[i]  <= '0;
            end
            r_busy     <= '0;
            r_epoch    <= '0;
            r_rr       <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_if_valid <= 1'b0;
            r_if_tid   <= '0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            if (w_req_fire) begin
                r_pc[w_sel]     <= r_pc[w_sel] + 32'd4;
                r_tag_tid[r_wr] <= w_sel;
                r_tag_ep[r_wr]  <= r_epoch[w_sel];
                r_tag_pc[r_wr]  <= r_pc[w_sel];
                r_wr            <= r_wr + TID_W'(1);
                r_rr            <= w_sel + TID_W'(1);
            end
            // The redirected thread is excluded from scheduling, so this never collides with the +4.
            if (redirect_valid) begin
                r_pc[redirect_tid]    <= w_redir_target;
                r_epoch[redirect_tid] <= ~r_epoch[redirect_tid];
            end
            if (w_rsp_fire) begin
                r_rd <= r_rd + TID_W'(1);
            end
            r_count <= r_count + {{TID_W{1'b0}}, w_req_fire} - {{TID_W{1'b0}}, w_rsp_fire};
            r_busy  <= (r_busy | w_set_mask) & ~w_clr_mask;

            if (w_load) begin
                r_if_valid <= 1'b1;
                r_if_tid   <= w_head_tid;
                r_if_pc    <= r_tag_pc[r_rd];
                r_if_instr <= imem_rsp_data;
            end else if (if_ready || w_kill) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign if_valid = r_if_valid;
    assign if_tid   = r_if_tid;
    assign if_pc    = r_if_pc;
    assign if_instr = r_if_instr;

endmodule

// File: tb/tb_rv_fetch_mt.sv
// tb/tb_rv_fetch_mt.sv - directed testbench for rv_fetch_mt
// Memory returns addr + 0x1000_0000 with one cycle latency unless responses are held off.
module tb_rv_fetch_mt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  thread_en = 4'b1111;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_tid = 2'd0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [1:0]  if_tid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int vectors = 0;
    int miscompares = 0;
    bit rsp_en = 1'b1;

    logic [31:0] mem_q[$];
    logic [31:0] req_log[$];
    logic [1:0]  out_tid[$];
    logic [31:0] out_pc[$];
    logic [31:0] out_instr[$];

    rv_fetch_mt #(.NTHREADS(4), .TID_W(2), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .thread_en(thread_en),
        .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_tid(if_tid), .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] req_at(input int k);
        return (k < req_log.size()) ? req_log[k] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] tid_at(input int k);
        return (k < out_tid.size()) ? {30'd0, out_tid[k]} : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] pc_at(input int k);
        return (k < out_pc.size()) ? out_pc[k] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] instr_at(input int k);
        return (k < out_instr.size()) ? out_instr[k] : 32'hDEAD_BEEF;
    endfunction

    // Called at a negedge with inputs set; records the handshakes of the coming posedge.
    task automatic step();
        imem_rsp_valid = rsp_en && (mem_q.size() != 0);
        imem_rsp_data  = (mem_q.size() != 0) ? mem_q[0] + 32'h1000_0000 : 32'h0;
        #1;
        if (if_valid && if_ready) begin
            out_tid.push_back(if_tid);
            out_pc.push_back(if_pc);
            out_instr.push_back(if_instr);
        end
        if (imem_rsp_valid && imem_rsp_ready) void'(mem_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
            req_log.push_back(imem_req_addr);
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        mem_q.delete();
        req_log.delete();
        out_tid.delete();
        out_pc.delete();
        out_instr.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        rsp_en = 1'b1;
        clear_logs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_rsp_ready", {31'd0, imem_rsp_ready}, 32'd1);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_tid", {30'd0, if_tid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);

        // All four threads, round robin.
        do_reset();
        thread_en = 4'b1111;
        repeat (8) step();
        chk("rr_req0", req_at(0), 32'h0);
        chk("rr_req3", req_at(3), 32'h0);
        chk("rr_req4", req_at(4), 32'h4);
        chk("rr_req7", req_at(7), 32'h4);
        for (int k = 0; k < 4; k++) chk("rr_tid", tid_at(k), k);
        chk("rr_pc4", pc_at(4), 32'h4);
        chk("rr_tid4", tid_at(4), 32'd0);
        chk("rr_instr4", instr_at(4), 32'h1000_0004);

        // Only threads 0 and 2 enabled.
        do_reset();
        thread_en = 4'b0101;
        repeat (6) step();
        chk("en_req_cnt", req_log.size(), 32'd6);
        chk("en_req2", req_at(2), 32'h4);
        chk("en_req5", req_at(5), 32'h8);
        chk("en_tid0", tid_at(0), 32'd0);
        chk("en_tid1", tid_at(1), 32'd2);
        chk("en_tid2", tid_at(2), 32'd0);
        chk("en_tid3", tid_at(3), 32'd2);
        thread_en = 4'b1010;
        repeat (2) step();
        chk("en_t3_first", req_at(6), 32'h0);
        chk("en_t1_first", req_at(7), 32'h0);

        // Redirect thread 1 while its fetch at 0x8 is outstanding.
        do_reset();
        thread_en = 4'b0010;
        repeat (5) step();
        chk("rd_req8", req_at(2), 32'h8);
        rsp_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_tid = 2'd1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        rsp_en = 1'b1;
        #1;
        chk("rd_stale_rsp_ready", {31'd0, imem_rsp_ready}, 32'd1);
        step();
        repeat (3) step();
        chk("rd_out_cnt", out_pc.size(), 32'd3);
        chk("rd_req_new", req_at(3), 32'h100);
        chk("rd_out_pc", pc_at(2), 32'h100);
        chk("rd_out_tid", tid_at(2), 32'd1);
        chk("rd_out_instr", instr_at(2), 32'h1000_0100);

        // Decode stall for five cycles with a full output register.
        do_reset();
        thread_en = 4'b1111;
        repeat (3) step();
        if_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("st_valid", {31'd0, if_valid}, 32'd1);
            chk("st_tid", {30'd0, if_tid}, 32'd1);
            chk("st_pc", if_pc, 32'h0);
            chk("st_instr", if_instr, 32'h1000_0000);
            chk("st_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
        end
        if_ready = 1'b1;
        repeat (12) step();
        chk("st_out_enough", {31'd0, out_pc.size() >= 8}, 32'd1);
        for (int k = 0; k < 6; k++) chk("st_tid_seq", tid_at(k), k % 4);
        for (int k = 0; k < out_pc.size(); k++) chk("st_pc_order", pc_at(k), req_at(k));

        // Redirect thread 2 to the top of the address space.
        do_reset();
        thread_en = 4'b0100;
        redirect_valid = 1'b1;
        redirect_tid = 2'd2;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("wr_redir_blocks", {31'd0, imem_req_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        repeat (5) step();
        chk("wr_req0", req_at(0), 32'hFFFF_FFFC);
        chk("wr_req1", req_at(1), 32'h0);
        chk("wr_out_tid", tid_at(0), 32'd2);
        chk("wr_out_pc0", pc_at(0), 32'hFFFF_FFFC);
        chk("wr_out_instr0", instr_at(0), 32'h0FFF_FFFC);
        chk("wr_out_pc1", pc_at(1), 32'h0);

        // Reset with three fetches outstanding and a valid output.
        do_reset();
        thread_en = 4'b1111;
        repeat (2) step();
        rsp_en = 1'b0;
        if_ready = 1'b0;
        repeat (2) step();
        chk("mr_outstanding", mem_q.size(), 32'd3);
        chk("mr_pre_valid", {31'd0, if_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_if_valid", {31'd0, if_valid}, 32'd0);
        chk("mr_req_valid", {31'd0, imem_req_valid}, 32'd0);
        clear_logs();
        @(negedge clk);
        rst = 1'b0;
        rsp_en = 1'b1;
        if_ready = 1'b1;
        repeat (5) step();
        chk("mr_req0", req_at(0), 32'h0);
        chk("mr_req3", req_at(3), 32'h0);
        chk("mr_req4", req_at(4), 32'h4);
        chk("mr_out_tid0", tid_at(0), 32'd0);
        chk("mr_out_pc0", pc_at(0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
